// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: the fetch stage's signal bundle.
//   imem_*      : request/response channel to instruction memory
//   redirect*   : new-PC request from the datapath (branch, j, jal, jr)
//   instr_*     : head-of-queue instruction handed to decode (valid/ready)
// modport master is taken by the fetch unit; slave by its environment.
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pcplus4;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, pcplus4,
    input  imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, pcplus4,
    output imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: sequential instruction fetch with a small prefetch queue.
// Issues word addresses to imem (one request in flight at most), queues
// returned {word, pc} pairs and presents the head to decode. A redirect
// flushes the queue and marks any in-flight fetch stale so its word is
// dropped when it returns.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : ifetch_unit_if.master (imem channel, redirect, decode side)
// Parameters: DEPTH (queue entries, power of two >= 2), RESET_PC.
// Optional: define IFETCH_BYPASS_EN to forward a response straight to
// decode when the queue is empty (saves one cycle of latency).
module ifetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  ifetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]             fetch_pc, pend_pc, tgt;
  logic                    outstanding, stale;
  logic [CW-1:0]           count;
  logic [AW-1:0]           head, tail;
  logic [DEPTH-1:0][31:0]  q_word, q_pc;
  logic                    q_empty, full, accept, resp, fresh, push, pop;

  assign q_empty = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign tgt     = bus.redirect_pc & ~32'h3;

  assign bus.imem_req  = !reset && !outstanding && !bus.redirect && !full;
  assign bus.imem_addr = fetch_pc;

  assign accept = bus.imem_req && bus.imem_ready;
  assign resp   = bus.imem_rvalid && outstanding;
  // A response is only worth keeping if no redirect overtook it.
  assign fresh  = resp && !stale && !bus.redirect;

`ifdef IFETCH_BYPASS_EN
  logic bypass;
  assign bypass          = q_empty && fresh;
  assign bus.instr_valid = !q_empty || bypass;
  assign bus.instr       = bypass ? bus.imem_rdata : q_word[head];
  assign bus.instr_pc    = bypass ? pend_pc : q_pc[head];
  // A bypassed word that decode takes right away never enters the queue.
  assign push            = fresh && !(bypass && bus.instr_ready);
  assign pop             = !q_empty && bus.instr_ready && !bus.redirect;
`else
  assign bus.instr_valid = !q_empty;
  assign bus.instr       = q_word[head];
  assign bus.instr_pc    = q_pc[head];
  assign push            = fresh;
  assign pop             = !q_empty && bus.instr_ready && !bus.redirect;
`endif

  assign bus.pcplus4 = bus.instr_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      pend_pc     <= RESET_PC;
      outstanding <= 1'b0;
      stale       <= 1'b0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      q_word      <= '0;
      q_pc        <= {DEPTH{RESET_PC}};
    end else begin
      // accept and resp never coincide: a request needs !outstanding.
      if (resp) outstanding <= 1'b0;
      if (accept) begin
        outstanding <= 1'b1;
        pend_pc     <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (bus.redirect) begin
        fetch_pc <= tgt;
        count    <= '0;
        head     <= '0;
        tail     <= '0;
        // Fetch still in flight: its word belongs to the old path.
        if (outstanding && !bus.imem_rvalid) stale <= 1'b1;
        else if (resp)                       stale <= 1'b0;
      end else begin
        if (resp) stale <= 1'b0;
        if (push) begin
          q_word[tail] <= bus.imem_rdata;
          q_pc[tail]   <= pend_pc;
          tail         <= tail + AW'(1);
        end
        if (pop) head <= head + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef IFETCH_BYPASS_EN
  localparam int FIRST_LAT = 1;
`else
  localparam int FIRST_LAT = 2;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ifetch_unit_if bus();
  ifetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0, errors = 0, cyc = 0;
  int lat = 1;
  bit ready_toggle = 1'b0;

  typedef struct { int due; logic [31:0] addr; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] p4; int c; } del_t;
  typedef struct { logic [31:0] w; logic [31:0] pc; } ent_t;

  mreq_t       memq[$];
  int          late_due = -1;
  del_t        dlog[$];
  logic [31:0] alog[$];
  int          acyc[$];
  int          first_valid = -1;

  // reference model state
  ent_t        mdl_q[$];
  logic [31:0] m_fetch = RST_PC, m_pend = RST_PC;
  bit          m_out = 1'b0, m_stale = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] del_pc(input int k);
    return (k < dlog.size()) ? dlog[k].pc : 32'hEEEE_EEEE;
  endfunction
  function automatic logic [31:0] del_p4(input int k);
    return (k < dlog.size()) ? dlog[k].p4 : 32'hEEEE_EEEE;
  endfunction
  function automatic logic [31:0] acc_addr(input int k);
    return (k < alog.size()) ? alog[k] : 32'hEEEE_EEEE;
  endfunction
  function automatic int acc_cyc(input int k);
    return (k < acyc.size()) ? acyc[k] : -1;
  endfunction

  // memory: drives response/ready at the start of each cycle
  always @(negedge clk) begin
    cyc++;
    bus.imem_ready = ready_toggle ? ((cyc % 3) != 1) : 1'b1;
    if (memq.size() > 0 && memq[0].due == cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(memq[0].addr);
      void'(memq.pop_front());
    end else if (late_due == cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0BAD_0BAD;
    end
  end

  // compare process: model outputs vs DUT each cycle, then advance model
  bit          e_valid, e_req, fresh, byp, pop;
  logic [31:0] e_instr, e_pc;
  always begin
    @(negedge clk);
    #4;
    if (reset) begin
      chk("req_in_reset", {31'b0, bus.imem_req}, 32'd0);
      if (memq.size() > 0) late_due = cyc + 1;
      memq.delete();
      mdl_q.delete();
      m_fetch = RST_PC; m_pend = RST_PC; m_out = 1'b0; m_stale = 1'b0;
      first_valid = -1;
    end else begin
      fresh = bus.imem_rvalid && m_out && !m_stale && !bus.redirect;
      e_req = !m_out && !bus.redirect && (mdl_q.size() < DEPTH);
      byp = 1'b0;
`ifdef IFETCH_BYPASS_EN
      byp = fresh && (mdl_q.size() == 0);
`endif
      e_valid = (mdl_q.size() > 0) || byp;
      e_instr = 32'h0; e_pc = 32'h0;
      if (byp) begin
        e_instr = mem_word(m_pend); e_pc = m_pend;
      end else if (mdl_q.size() > 0) begin
        e_instr = mdl_q[0].w; e_pc = mdl_q[0].pc;
      end
      chk("imem_req", {31'b0, bus.imem_req}, {31'b0, e_req});
      chk("imem_addr", bus.imem_addr, m_fetch);
      chk("instr_valid", {31'b0, bus.instr_valid}, {31'b0, e_valid});
      if (e_valid) begin
        chk("instr", bus.instr, e_instr);
        chk("instr_pc", bus.instr_pc, e_pc);
        chk("pcplus4", bus.pcplus4, e_pc + 32'd4);
      end
      if (bus.instr_valid && first_valid < 0) first_valid = cyc;
      if (bus.imem_req && bus.imem_ready) begin
        memq.push_back('{cyc + lat, bus.imem_addr});
        alog.push_back(bus.imem_addr);
        acyc.push_back(cyc);
      end
      pop = e_valid && bus.instr_ready && !bus.redirect;
      if (pop) dlog.push_back('{bus.instr_pc, bus.pcplus4, cyc});
      if (bus.redirect) begin
        mdl_q.delete();
        m_fetch = bus.redirect_pc & ~32'h3;
        if (m_out && bus.imem_rvalid) begin m_out = 1'b0; m_stale = 1'b0; end
        else if (m_out) m_stale = 1'b1;
      end else begin
        if (pop && !byp) void'(mdl_q.pop_front());
        if (bus.imem_rvalid && m_out) begin
          m_out = 1'b0;
          if (m_stale) m_stale = 1'b0;
          else if (!(byp && pop)) mdl_q.push_back('{mem_word(m_pend), m_pend});
        end
        if (e_req && bus.imem_ready) begin
          m_out = 1'b1; m_pend = m_fetch; m_fetch = m_fetch + 32'd4;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int l, input bit rdy);
    reset = 1'b1; bus.redirect = 1'b0; ready_toggle = 1'b0;
    tick();
    lat = l; bus.instr_ready = rdy; reset = 1'b0;
    alog.delete(); acyc.delete(); dlog.delete();
  endtask

  task automatic wait_logs(input int na, input int nd, input int budget, input string nm);
    int k = 0;
    while ((alog.size() < na || dlog.size() < nd) && k < budget) begin
      tick(); k++;
    end
    chk(nm, (alog.size() >= na && dlog.size() >= nd) ? 32'd1 : 32'd0, 32'd1);
  endtask

  int c0, n0, na, rcyc, k;

  initial begin
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.instr_ready = 1'b0;
    repeat (2) tick();

    // sequential fetch, L=1, decode always ready
    do_reset(1, 1'b1);
    c0 = cyc;
    #2;
    chk("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_pc", bus.instr_pc, RST_PC);
    chk("rst_pcplus4", bus.pcplus4, RST_PC + 32'd4);
    chk("rst_addr", bus.imem_addr, RST_PC);
    chk("first_req", {31'b0, bus.imem_req}, 32'd1);
    wait_logs(0, 6, 60, "seq_timeout");
    chk("seq_pc0", del_pc(0), 32'h0);
    chk("seq_pc1", del_pc(1), 32'h4);
    chk("seq_pc2", del_pc(2), 32'h8);
    chk("seq_p4_2", del_p4(2), 32'hC);
    chk("first_valid_lat", first_valid - c0, FIRST_LAT);
    chk("throughput", dlog.size() > 1 ? dlog[1].c - dlog[0].c : -1, 2);
    ready_toggle = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.instr_ready = (i % 4) != 3;
      tick();
    end
    ready_toggle = 1'b0;

    // queue fills while decode stalls
    do_reset(1, 1'b0);
    repeat (20) tick();
    #2;
    chk("full_req", {31'b0, bus.imem_req}, 32'd0);
    chk("full_accepts", alog.size(), 32'd4);
    bus.instr_ready = 1'b1;
    wait_logs(5, 4, 40, "drain_timeout");
    chk("drain0", del_pc(0), 32'h0);
    chk("drain1", del_pc(1), 32'h4);
    chk("drain2", del_pc(2), 32'h8);
    chk("drain3", del_pc(3), 32'hC);
    chk("resume_addr", acc_addr(4), 32'h10);

    // redirect while fetch of 8 is in flight, L=3
    do_reset(3, 1'b1);
    k = 0;
    while (alog.size() < 3 && k < 100) begin tick(); k++; end
    chk("stale_pre_addr", acc_addr(2), 32'h8);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0103;
    n0 = dlog.size(); na = alog.size(); rcyc = cyc;
    tick();
    bus.redirect = 1'b0;
    wait_logs(na + 1, n0 + 1, 60, "stale_timeout");
    chk("stale_next_addr", acc_addr(na), 32'h100);
    chk("stale_first_pc", del_pc(n0), 32'h100);
    chk("stale_resume_cyc", acc_cyc(na) - rcyc, 32'd3);

    // redirect coinciding with a valid response and a pop
    do_reset(1, 1'b0);
    repeat (5) tick();
    k = 0;
    while (!(bus.imem_rvalid && bus.instr_valid) && k < 50) begin tick(); k++; end
    bus.instr_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0200;
    n0 = dlog.size();
    tick();
    bus.redirect = 1'b0;
    #2;
    chk("rr_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("rr_req", {31'b0, bus.imem_req}, 32'd1);
    chk("rr_addr", bus.imem_addr, 32'h200);
    wait_logs(0, n0 + 1, 40, "rr_timeout");
    chk("rr_first_pc", del_pc(n0), 32'h200);

    // address wrap
    do_reset(1, 1'b1);
    tick();
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8;
    na = alog.size(); n0 = dlog.size();
    tick();
    bus.redirect = 1'b0;
    wait_logs(na + 3, n0 + 2, 40, "wrap_timeout");
    chk("wrap_a0", acc_addr(na), 32'hFFFF_FFF8);
    chk("wrap_a1", acc_addr(na + 1), 32'hFFFF_FFFC);
    chk("wrap_a2", acc_addr(na + 2), 32'h0);
    chk("wrap_pc", del_pc(n0 + 1), 32'hFFFF_FFFC);
    chk("wrap_p4", del_p4(n0 + 1), 32'h0);

    // reset with 3 queued words and one fetch in flight
    do_reset(3, 1'b0);
    k = 0;
    while (alog.size() < 4 && k < 100) begin tick(); k++; end
    chk("mid_pre_valid", {31'b0, bus.instr_valid}, 32'd1);
    do_reset(3, 1'b0);
    #2;
    chk("mid_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("mid_addr", bus.imem_addr, RST_PC);
    chk("mid_instr", bus.instr, 32'd0);
    chk("mid_late_seen", {31'b0, bus.imem_rvalid}, 32'd1);
    bus.instr_ready = 1'b1;
    wait_logs(0, 2, 60, "mid_timeout");
    chk("mid_pc0", del_pc(0), 32'h0);
    chk("mid_pc1", del_pc(1), 32'h4);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
